// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Merges the core's instruction-fetch port and data port onto one
// single-ported memory bus. Only one bus transaction runs at a time, and data
// requests win over fetches. Each finished result is held until the pipeline
// advances. A watchdog aborts any transaction that waits too long for
// m_ack_n, and it records the first such event in a sticky error flag.
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   ireq, iad                 fetch request and fetch address
//   idt, acki_n               fetched instruction, fetch ack (0 = valid/no stall)
//   dreq, dwrite, dsize, dad, dwdata
//                             data request, store flag, size, address, store data
//   drdata, ackd_n            load data, data ack (0 = valid/no stall)
//   m_req, m_write, m_size, m_addr, m_wdata
//                             shared memory bus request and attributes
//   m_rdata, m_ack_n          memory read data and completion (0 = done)
//   bus_err, err_addr         sticky timeout flag and first failing address
module unified_mem_arbiter #(
  parameter int          TIMEOUT       = 256,
  parameter logic [1:0]  IF_SIZE       = 2'b10,
  parameter logic [31:0] IF_ABORT_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ireq,
  input  logic [31:0] iad,
  output logic [31:0] idt,
  output logic        acki_n,
  input  logic        dreq,
  input  logic        dwrite,
  input  logic [1:0]  dsize,
  input  logic [31:0] dad,
  input  logic [31:0] dwdata,
  output logic [31:0] drdata,
  output logic        ackd_n,
  output logic        m_req,
  output logic        m_write,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack_n,
  output logic        bus_err,
  output logic [31:0] err_addr
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, I_BUS, D_BUS} state_t;

  state_t            state_q, state_d;
  logic              i_done_q, d_done_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              m_req_q, m_write_q;
  logic [1:0]        m_size_q;
  logic [31:0]       m_addr_q, m_wdata_q;
  logic [31:0]       idt_q, drdata_q;
  logic              bus_err_q;
  logic [31:0]       err_addr_q;

  logic in_bus, timeout, finish, advance;

  assign in_bus  = (state_q != IDLE);
  // A memory ack in the last allowed cycle counts as completion, not abort.
  assign timeout = in_bus && m_ack_n && (cnt_q == CNT_LAST);
  assign finish  = in_bus && (!m_ack_n || timeout);

  // The acks depend only on the requests and registered flags, so there is no
  // combinational path from the memory bus to the core.
  assign acki_n  = ireq & ~i_done_q;
  assign ackd_n  = dreq & ~d_done_q;
  assign advance = !acki_n && !ackd_n;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dreq && !d_done_q)      state_d = D_BUS;
        else if (ireq && !i_done_q) state_d = I_BUS;
      end
      default: if (finish) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      cnt_q      <= '0;
      m_req_q    <= 1'b0;
      m_write_q  <= 1'b0;
      m_size_q   <= 2'b00;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      idt_q      <= '0;
      drdata_q   <= '0;
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (advance) begin
        i_done_q <= 1'b0;
        d_done_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (state_d == D_BUS) begin
            m_req_q   <= 1'b1;
            m_write_q <= dwrite;
            m_size_q  <= dsize;
            m_addr_q  <= dad;
            m_wdata_q <= dwdata;
            cnt_q     <= '0;
          end else if (state_d == I_BUS) begin
            m_req_q   <= 1'b1;
            m_write_q <= 1'b0;
            m_size_q  <= IF_SIZE;
            m_addr_q  <= iad;
            cnt_q     <= '0;
          end
        end
        default: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (finish) begin
            // Size/addr/wdata keep their last values while the bus is idle.
            m_req_q   <= 1'b0;
            m_write_q <= 1'b0;
            if (timeout && !bus_err_q) begin
              bus_err_q  <= 1'b1;
              err_addr_q <= m_addr_q;
            end
            // If the owner has dropped its request, the result is discarded.
            if (state_q == I_BUS && ireq) begin
              i_done_q <= 1'b1;
              idt_q    <= timeout ? IF_ABORT_INSN : m_rdata;
            end
            if (state_q == D_BUS && dreq) begin
              d_done_q <= 1'b1;
              if (!m_write_q) drdata_q <= timeout ? 32'h0 : m_rdata;
            end
          end
        end
      endcase
    end
  end

  assign m_req    = m_req_q;
  assign m_write  = m_write_q;
  assign m_size   = m_size_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign idt      = idt_q;
  assign drdata   = drdata_q;
  assign bus_err  = bus_err_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter. A small memory responder with a
// programmable wait count supplies m_ack_n/m_rdata. Expected core-side results
// go into a scoreboard queue when a request is driven, and they are checked
// when the matching ack goes low.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq, dreq, dwrite;
  logic [31:0] iad, dad, dwdata;
  logic [1:0]  dsize;
  logic [31:0] idt, drdata, m_addr, m_wdata, m_rdata, err_addr;
  logic        acki_n, ackd_n, m_req, m_write, m_ack_n, bus_err;
  logic [1:0]  m_size;

  int tests = 0;
  int fails = 0;

  // memory responder configuration
  logic [7:0] mem_wait = 8'd0;
  logic       mem_hang = 1'b0;
  logic [7:0] wcnt = 8'd0;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  unified_mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ireq(ireq), .iad(iad), .idt(idt), .acki_n(acki_n),
    .dreq(dreq), .dwrite(dwrite), .dsize(dsize), .dad(dad), .dwdata(dwdata),
    .drdata(drdata), .ackd_n(ackd_n),
    .m_req(m_req), .m_write(m_write), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack_n(m_ack_n),
    .bus_err(bus_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h100)       return 32'hDEAD_BEEF;
    else if (a == 32'h1000) return 32'h0050_0093;
    else                    return {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge clk) begin
    if (!m_req || !m_ack_n) wcnt <= 8'd0;
    else                    wcnt <= wcnt + 8'd1;
  end
  assign m_ack_n = ~(m_req && !mem_hang && (wcnt == mem_wait));
  assign m_rdata = memval(m_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input bit is_d);
    exp_t e;
    tests++;
    assert (sbq.size() != 0) else begin
      fails++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("sb_port", 32'(is_d), 32'(e.is_d));
      chk(is_d ? "sb_drdata" : "sb_idt", is_d ? drdata : idt, e.data);
    end
  endtask

  // Waits until the selected ack goes low, bounded by budget cycles.
  task automatic wait_ack(input bit is_d, input int budget, output int lat);
    bit seen = 1'b0;
    lat = 0;
    while (!seen && lat < budget) begin
      tick();
      lat++;
      if ((is_d ? ackd_n : acki_n) == 1'b0) seen = 1'b1;
    end
    tests++;
    assert (seen) else begin
      fails++;
      $error("FAIL ack_wait: observed no ack in %0d cycles expected ack", budget);
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1; ireq = 1'b1; dreq = 1'b0; dwrite = 1'b0; dsize = 2'b00;
    iad = '0; dad = '0; dwdata = '0;

    // reset state
    tick(); tick();
    chk("rst_mreq", m_req, 0);     chk("rst_mwrite", m_write, 0);
    chk("rst_msize", m_size, 0);   chk("rst_maddr", m_addr, 0);
    chk("rst_mwdata", m_wdata, 0); chk("rst_idt", idt, 0);
    chk("rst_drdata", drdata, 0);  chk("rst_buserr", bus_err, 0);
    chk("rst_erraddr", err_addr, 0);
    chk("rst_acki", acki_n, 1);    chk("rst_ackd", ackd_n, 0);
    ireq = 1'b0;
    tick();
    rst = 1'b0;

    // no requests: bus quiet, no stall
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("idle_mreq", m_req, 0);
      chk("idle_acki", acki_n, 0);
      chk("idle_ackd", ackd_n, 0);
    end

    // fetch only, zero-wait memory
    mem_wait = 8'd0;
    ireq = 1'b1; iad = 32'h1000;
    sbq.push_back('{1'b0, memval(32'h1000)});
    chk("f_c0_mreq", m_req, 0);
    tick();
    chk("f_c1_mreq", m_req, 1);   chk("f_c1_addr", m_addr, 32'h1000);
    chk("f_c1_size", m_size, 2);  chk("f_c1_write", m_write, 0);
    chk("f_c1_acki", acki_n, 1);
    tick();
    chk("f_c2_acki", acki_n, 0);
    chk("f_c2_idt", idt, 32'h0050_0093);
    sb_check(1'b0);
    ireq = 1'b0;
    tick(); tick();

    // fetch and load together: data first, fetch afterwards
    ireq = 1'b1; iad = 32'h2000;
    dreq = 1'b1; dwrite = 1'b0; dad = 32'h100; dsize = 2'b10;
    sbq.push_back('{1'b1, 32'hDEAD_BEEF});
    sbq.push_back('{1'b0, memval(32'h2000)});
    tick();
    chk("fl_c1_mreq", m_req, 1); chk("fl_c1_addr", m_addr, 32'h100);
    chk("fl_c1_ackd", ackd_n, 1); chk("fl_c1_acki", acki_n, 1);
    tick();
    chk("fl_c2_ackd", ackd_n, 0); chk("fl_c2_acki", acki_n, 1);
    chk("fl_c2_mreq", m_req, 0);
    sb_check(1'b1);
    tick();
    chk("fl_c3_mreq", m_req, 1); chk("fl_c3_addr", m_addr, 32'h2000);
    chk("fl_c3_ackd", ackd_n, 0); chk("fl_c3_drdata", drdata, 32'hDEAD_BEEF);
    tick();
    chk("fl_c4_acki", acki_n, 0); chk("fl_c4_ackd", ackd_n, 0);
    sb_check(1'b0);
    tick();
    chk("fl_c5_acki", acki_n, 1); chk("fl_c5_ackd", ackd_n, 1);
    ireq = 1'b0; dreq = 1'b0;
    tick(); tick();

    // store with three memory wait cycles
    mem_wait = 8'd3;
    dreq = 1'b1; dwrite = 1'b1; dad = 32'h200; dwdata = 32'h1234_5678; dsize = 2'b00;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("st_mreq", m_req, 1);   chk("st_write", m_write, 1);
      chk("st_wdata", m_wdata, 32'h1234_5678);
      chk("st_size", m_size, 0);  chk("st_ackd", ackd_n, 1);
    end
    tick();
    chk("st_c5_ackd", ackd_n, 0); chk("st_c5_drdata", drdata, 32'hDEAD_BEEF);
    chk("st_c5_write", m_write, 0);
    dreq = 1'b0; dwrite = 1'b0;
    tick(); tick();

    // fetch timeout at 0x40
    mem_hang = 1'b1;
    ireq = 1'b1; iad = 32'h40;
    sbq.push_back('{1'b0, 32'h0000_0013});
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("to_mreq", m_req, 1);
      chk("to_acki", acki_n, 1);
    end
    tick();
    chk("to_c9_acki", acki_n, 0);  chk("to_c9_mreq", m_req, 0);
    chk("to_c9_buserr", bus_err, 1); chk("to_c9_erraddr", err_addr, 32'h40);
    sb_check(1'b0);
    ireq = 1'b0;
    tick(); tick();

    // second timeout (load) keeps the first error address
    dreq = 1'b1; dad = 32'h80;
    sbq.push_back('{1'b1, 32'h0});
    wait_ack(1'b1, 20, lat);
    chk("to2_lat", lat, 9);
    sb_check(1'b1);
    chk("to2_erraddr", err_addr, 32'h40); chk("to2_buserr", bus_err, 1);
    dreq = 1'b0;
    mem_hang = 1'b0;
    tick(); tick();

    // reset in cycle 2 of a waited load, then re-issue
    mem_wait = 8'd5;
    dreq = 1'b1; dwrite = 1'b0; dad = 32'h300;
    sbq.push_back('{1'b1, memval(32'h300)});
    tick();
    chk("rm_c1_mreq", m_req, 1);
    tick();
    chk("rm_c2_mreq", m_req, 1);
    rst = 1'b1;
    tick();
    chk("rm_c3_mreq", m_req, 0);  chk("rm_c3_ackd", ackd_n, 1);
    chk("rm_c3_buserr", bus_err, 0); chk("rm_c3_erraddr", err_addr, 0);
    rst = 1'b0;
    tick();
    chk("rm_c4_mreq", m_req, 1);  chk("rm_c4_addr", m_addr, 32'h300);
    wait_ack(1'b1, 20, lat);
    chk("rm_lat", lat, 6);
    sb_check(1'b1);
    dreq = 1'b0;
    tick(); tick();

    chk("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbitrates the core's separate instruction-fetch port (IAD/IDT/ACKI_n) and data port (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n) onto one shared single-ported memory bus, so the core can run on a unified memory.
- Sits between the core ports and the memory.
- Runs one bus transaction at a time, giving data priority over fetch.
- Holds each completed result until the pipeline advances.
- Includes a bus-timeout watchdog with a sticky error flag.

## Interface

Parameters:
- TIMEOUT, 256: cycles a bus transaction may wait for m_ack_n before it is aborted (≥2).
- IF_SIZE, 2'b10: SIZE encoding driven for instruction fetches (32-bit word).
- IF_ABORT_INSN, 32'h0000_0013: instruction returned on fetch timeout (NOP).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ireq  in  1  fetch request; tied high by the core.
- iad  in  32  fetch address.
- idt  out  32  fetched instruction.
- acki_n  out  1  0 = fetch result valid / not stalling.
- dreq  in  1  data request (MREQ).
- dwrite  in  1  1 = store.
- dsize  in  2  data access size.
- dad  in  32  data address.
- dwdata  in  32  store data.
- drdata  out  32  load data.
- ackd_n  out  1  0 = data result valid / not stalling.
- m_req  out  1  memory bus request.
- m_write  out  1  memory bus write.
- m_size  out  2  memory bus size.
- m_addr  out  32  memory bus address.
- m_wdata  out  32  memory bus write data.
- m_rdata  in  32  memory bus read data.
- m_ack_n  in  1  memory done; 0 = completes this cycle.
- bus_err  out  1  sticky timeout flag.
- err_addr  out  32  address of the first timed-out transaction.

## Operation

- FSM states: IDLE, I_BUS, D_BUS. Reset state is IDLE.
- **IDLE grant rule:**
  - If dreq && !d_done, go to D_BUS.
  - Else if ireq && !i_done, go to I_BUS.
  - Else stay in IDLE.
  - Data wins when both are pending.
- **Grant capture.** On grant, latch the bus attributes:
  - D_BUS: addr ← dad, write ← dwrite, size ← dsize, wdata ← dwdata.
  - I_BUS: addr ← iad, write ← 0, size ← IF_SIZE.
- **Bus outputs.**
  - In I_BUS/D_BUS: m_req=1, and m_write/m_size/m_addr/m_wdata come from the latches.
  - In IDLE: m_req=0, m_write=0, others hold their last values.
- **Completion.** In a bus state, when m_ack_n=0:
  - Go to IDLE.
  - I_BUS: idt ← m_rdata, set i_done.
  - D_BUS: set d_done; drdata ← m_rdata for a read; drdata is unchanged for a write.
  - If the owning request has dropped by then, discard the result and leave the done flag clear.
- **Timeout.**
  - A wait counter clears on grant and increments each bus-state cycle.
  - If it reaches TIMEOUT-1 with m_ack_n=1, abort: go to IDLE and set the owner's done flag.
  - Abort data: idt=IF_ABORT_INSN for a fetch, drdata=0 for a read.
  - On the first abort only, bus_err ← 1 and err_addr ← the latched addr. Both are cleared only by rst.
- **Core acks:**
  - acki_n = ireq & ~i_done
  - ackd_n = dreq & ~d_done
  - With no request, the ack is 0 (no stall).
- **Advance.** A cycle with acki_n=0 && ackd_n=0 is a pipeline advance. Both done flags clear at the end of that cycle.
  - A result completed early stays held (ack_n low, data stable) while the other port is still pending.
- A started transaction always runs to completion or timeout; there is no preemption.

## Timing

- **Reset values:**
  - FSM: IDLE; i_done=d_done=0; wait counter 0.
  - m_req=0, m_write=0, m_size=0, m_addr=0, m_wdata=0.
  - idt=0, drdata=0; bus_err=0, err_addr=0.
  - acki_n=ireq, ackd_n=dreq (combinational).
- **Latency (cycle 0 = request seen in IDLE):**
  - Cycle 1: m_req=1.
  - A zero-wait memory (m_ack_n=0 in cycle 1) gives ack_n=0 in cycle 2.
  - Each memory wait cycle adds one cycle.
- Back-to-back transactions have one IDLE cycle between m_req pulses.
- **Fetch and load both pending, zero-wait memory:**
  - D_BUS in cycle 1, I_BUS in cycle 3.
  - acki_n=ackd_n=0 in cycle 4; flags clear at the end of cycle 4.
- **Reset mid-transaction:** the next cycle is IDLE with m_req=0; pending results are lost and flags cleared.
- **Abort timing:** an abort occurs at the end of the TIMEOUT-th bus cycle; m_ack_n=0 in that same cycle counts as completion, not abort.
- No combinational path from m_* inputs to the core-side outputs; acki_n/ackd_n depend only on ireq/dreq and registered flags.

## Test plan

- Fetch only, zero-wait memory returning 32'h00500093 → m_req cycle 1, m_addr=iad; acki_n=0 and idt=32'h00500093 in cycle 2.
- ireq and dreq (load, dad=0x100, memory data 0xDEADBEEF) in cycle 0 → D_BUS first. ackd_n=0 from cycle 2 and held; fetch in cycle 3; both acks 0 in cycle 4, then both return to 1 in cycle 5.
- Store dad=0x200, dwdata=0x12345678, dsize=2'b00, memory 3 wait cycles → m_write=1 with m_wdata=0x12345678 for cycles 1–4; ackd_n=0 in cycle 5; drdata unchanged.
- Memory never acks a fetch at 0x40, TIMEOUT=8 → abort after cycle 8; idt=0x00000013 and acki_n=0 in cycle 9; bus_err=1, err_addr=0x40. A second timeout leaves err_addr=0x40.
- rst asserted in cycle 2 of a waited load → m_req=0 in cycle 3, d_done=0, bus_err=0; the load re-issues once rst drops.
- ireq=dreq=0 → m_req stays 0 and acki_n=ackd_n=0 every cycle.
